// File: rtl/adderc_mpseq.sv
// Multi-precision add/subtract sequencer: streams LSW-first word pairs
// through a WIDTH-bit carry adder, chaining the carry between words.
module adderc_mpseq #(
  parameter int WIDTH    = 32,
  parameter int NW_WIDTH = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                start,
  input  logic                sub_nadd,
  input  logic [NW_WIDTH-1:0] nwords,
  input  logic                abort,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out,
  output logic                out_last,
  output logic                done,
  output logic                cout,
  output logic                zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                op_sub;
  logic                carry;
  logic                zacc;
  logic [NW_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]    b_op;
  logic [WIDTH:0]      sum;
  logic                accept;
  logic                kill;

  // Subtraction is a + ~b + 1, the +1 coming from the preloaded carry.
  assign b_op   = op_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry};
  assign kill   = abort && (state != IDLE);
  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);
  assign done   = (state == FIN) && !abort;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (nwords == '0) ? FIN : RUN;
      end
      RUN: begin
        in_ready = !abort && (!out_valid || out_ready);
        if (in_valid && in_ready && cnt == NW_WIDTH'(1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_ready)
          state_nx = FIN;
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_sub    <= 1'b0;
      carry     <= 1'b0;
      zacc      <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      cout      <= 1'b0;
      zero      <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_sub <= sub_nadd;
            carry  <= sub_nadd;
            zacc   <= 1'b1;
            cnt    <= nwords;
            if (nwords == '0) begin
              cout <= sub_nadd;
              zero <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            out       <= sum[WIDTH-1:0];
            out_valid <= 1'b1;
            carry     <= sum[WIDTH];
            zacc      <= zacc && (sum[WIDTH-1:0] == '0);
            cnt       <= cnt - 1'b1;
            out_last  <= (cnt == NW_WIDTH'(1));
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            cout      <= carry;
            zero      <= zacc;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
